// File: rtl/vedic_mac_ctrl_pkg.sv
// Shared definitions for the Vedic MAC lane sequencer.
package vedic_mac_ctrl_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Operand width fed to the 8x8 multiplier.
   localparam int OPND_W        = 8;
   // Full-precision product width.
   localparam int PROD_W        = 16;
   // Default accumulator/result width.
   localparam int ACC_W_DEFAULT = 24;

endpackage : vedic_mac_ctrl_pkg

// File: rtl/vedic_mac_ctrl_mult.sv
// Combinational 8x8 unsigned multiplier, vertically-and-crosswise form:
// every output column k collects the crosswise bit products a[i]&b[k-i];
// the column counts are then merged with their binary weights.
module Vedic_8x8_Multiplier (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   // diag[k][i] holds a[i]&b[k-i] where that pairing exists, else 0.
   logic [14:0][7:0] diag;
   logic [3:0]       col_cnt;
   logic [15:0]      p_sum;

   generate
      for (genvar gi = 0; gi < 15; gi++) begin : g_col
         for (genvar gj = 0; gj < 8; gj++) begin : g_row
            if ((gi - gj) >= 0 && (gi - gj) < 8) begin : g_term
               assign diag[gi][gj] = a[gj] & b[gi-gj];
            end else begin : g_zero
               assign diag[gi][gj] = 1'b0;
            end
         end
      end
   endgenerate

   // Count each crosswise column and add it in at its weight; carries ripple naturally.
   always_comb begin
      p_sum   = '0;
      col_cnt = '0;
      for (int k = 0; k < 15; k++) begin
         col_cnt = '0;
         for (int i = 0; i < 8; i++) begin
            col_cnt = col_cnt + {3'b000, diag[k][i]};
         end
         p_sum = p_sum + ({12'b0, col_cnt} << k);
      end
   end

   assign p = p_sum;

endmodule : Vedic_8x8_Multiplier

// File: rtl/vedic_mac_ctrl.sv
// MAC lane sequencer: accepts a length-tagged job, streams operand pairs
// through a two-stage multiply pipeline into an accumulator and presents
// the dot product over a valid/ready handshake.
module vedic_mac_ctrl
   import vedic_mac_ctrl_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEFAULT,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] a_in,
   input  logic [OPND_W-1:0] b_in,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow
);

   localparam int SUM_W = ACC_W + 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OPND_W-1:0]   a_q, a_d;
   logic [OPND_W-1:0]   b_q, b_d;
   logic                v1_q, v1_d;
   logic [PROD_W-1:0]   prod_q;
   logic                v2_q;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                ovf_q, ovf_d;
   logic [PROD_W-1:0]   mult_p;
   logic [SUM_W-1:0]    sum_wide;
   logic                accept;

   Vedic_8x8_Multiplier u_mult (
      .a (a_q),
      .b (b_q),
      .p (mult_p)
   );

   assign accept   = in_valid & in_ready;
   // One spare bit on top of the accumulator catches the carry-out.
   assign sum_wide = {1'b0, acc_q} + SUM_W'(prod_q);

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = (len == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && cnt_q == CNT_W'(1)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Last product is in stage 2 and nothing is behind it.
            if (v2_q && !v1_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter, operand capture and accumulator next-state.
   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      v1_d  = accept;
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (state_q == ST_IDLE && start) begin
         cnt_d = len;
         acc_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (accept) begin
            cnt_d = cnt_q - CNT_W'(1);
            a_d   = a_in;
            b_d   = b_in;
         end
         if (v2_q) begin
            acc_d = sum_wide[ACC_W-1:0];
            if (sum_wide[ACC_W]) begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter, pipeline registers and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         v1_q   <= 1'b0;
         prod_q <= '0;
         v2_q   <= 1'b0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         v1_q   <= v1_d;
         prod_q <= mult_p;
         v2_q   <= v1_q;
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign acc_out  = acc_q;
   assign overflow = ovf_q;

endmodule : vedic_mac_ctrl

// File: tb/tb_vedic_mac_ctrl.sv
// Bench for vedic_mac_ctrl: two instances (24- and 16-bit accumulators)
// share one stimulus stream and are checked each cycle against a
// job-level model (running sum, beats remaining, result-ready cycle).
module tb_vedic_mac_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic [7:0]       a_in;
   logic [7:0]       b_in;
   logic             out_ready;

   logic             in_ready24, busy24, out_valid24, ovf24;
   logic [23:0]      acc24;
   logic             in_ready16, busy16, out_valid16, ovf16;
   logic [15:0]      acc16;

   int n_checks = 0;
   int n_errors = 0;

   // Job-level model state.
   int     cyc        = 0;
   bit     m_busy     = 1'b0;
   int     m_rem      = 0;
   int     m_valid_at = 0;
   longint m_sum      = 0;

   // Results captured when out_valid is first seen.
   longint res24, res16;
   longint rovf24, rovf16;
   int     wait_cnt;

   logic [7:0] op_a [256];
   logic [7:0] op_b [256];

   always #5 clk = ~clk;

   vedic_mac_ctrl #(.ACC_W(24), .CNT_W(CNT_W)) dut24 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready24), .a_in(a_in), .b_in(b_in),
      .busy(busy24), .out_valid(out_valid24), .out_ready(out_ready),
      .acc_out(acc24), .overflow(ovf24)
   );

   vedic_mac_ctrl #(.ACC_W(16), .CNT_W(CNT_W)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready16), .a_in(a_in), .b_in(b_in),
      .busy(busy16), .out_valid(out_valid16), .out_ready(out_ready),
      .acc_out(acc16), .overflow(ovf16)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a job is taken when idle and start is seen; each accepted pair
   // adds a*b exactly; the result is due two edges after the last beat
   // (or right away for an empty job) and is released by out_ready.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc        <= 0;
         m_busy     <= 1'b0;
         m_rem      <= 0;
         m_valid_at <= 0;
         m_sum      <= 0;
      end else begin
         cyc <= cyc + 1;
         if (!m_busy) begin
            if (start) begin
               m_busy     <= 1'b1;
               m_rem      <= int'(len);
               m_sum      <= 0;
               m_valid_at <= cyc + 1;
            end
         end else if (m_rem != 0) begin
            if (in_valid) begin
               m_sum <= m_sum + longint'(a_in) * longint'(b_in);
               m_rem <= m_rem - 1;
               if (m_rem == 1) m_valid_at <= cyc + 3;
            end
         end else if (cyc >= m_valid_at && out_ready) begin
            m_busy <= 1'b0;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   initial begin : compare
      bit exp_valid;
      bit exp_ready;
      @(negedge rst_n);
      forever begin
         @(negedge clk);
         exp_valid = m_busy && (m_rem == 0) && (cyc >= m_valid_at);
         exp_ready = m_busy && (m_rem != 0);
         chk("busy24",      busy24,      m_busy);
         chk("busy16",      busy16,      m_busy);
         chk("in_ready24",  in_ready24,  exp_ready);
         chk("in_ready16",  in_ready16,  exp_ready);
         chk("out_valid24", out_valid24, exp_valid);
         chk("out_valid16", out_valid16, exp_valid);
         if (!m_busy || exp_valid) begin
            chk("acc24", acc24, m_sum & 64'hFF_FFFF);
            chk("ovf24", ovf24, (m_sum >= 64'd16777216) ? 1 : 0);
            chk("acc16", acc16, m_sum & 64'hFFFF);
            chk("ovf16", ovf16, (m_sum >= 64'd65536) ? 1 : 0);
         end
      end
   end

   // Run one job. gap_mode: 0 back-to-back, 1 every other cycle, 2 random.
   // Starts and ends just after a falling edge.
   task automatic run_job(input int n, input int gap_mode, input int hold, input bit poke);
      int idx;
      int guard;
      int phase;
      bit v;
      start     = 1'b1;
      len       = 8'(n);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      len   = 8'($urandom);
      idx   = 0;
      guard = 0;
      phase = 0;
      while (idx < n && guard < 2000) begin
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (phase % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         in_valid = v;
         a_in     = v ? op_a[idx] : 8'($urandom);
         b_in     = v ? op_b[idx] : 8'($urandom);
         if (v && in_ready24) idx++;
         phase++;
         guard++;
         @(negedge clk);
      end
      if (idx < n) chk("beat_timeout", idx, n);
      in_valid = $urandom_range(0, 1) != 0;
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      guard    = 0;
      while (!out_valid24 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!out_valid24) chk("done_timeout", out_valid24, 1);
      wait_cnt = guard;
      res24    = longint'(acc24);
      res16    = longint'(acc16);
      rovf24   = longint'(ovf24);
      rovf16   = longint'(ovf16);
      for (int h = 0; h < hold; h++) begin
         start = poke;
         len   = 8'($urandom_range(1, 5));
         @(negedge clk);
      end
      start     = poke;
      out_ready = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   initial begin : stimulus
      int n;
      rst_n     = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      a_in      = '0;
      b_in      = '0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",      busy24,      0);
      chk("rst_in_ready",  in_ready24,  0);
      chk("rst_out_valid", out_valid24, 0);
      chk("rst_acc",       acc24,       0);
      chk("rst_ovf",       ovf24,       0);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back job.
      op_a[0] = 8'd2;   op_b[0] = 8'd3;
      op_a[1] = 8'd4;   op_b[1] = 8'd5;
      op_a[2] = 8'd255; op_b[2] = 8'd255;
      run_job(3, 0, 0, 1'b0);
      chk("t1_acc",   res24,    65051);
      chk("t1_ovf",   rovf24,   0);
      chk("t1_lat",   wait_cnt, 2);
      chk("t1_model", m_sum,    65051);

      // Zero-length job.
      run_job(0, 0, 0, 1'b0);
      chk("t2_acc", res24,    0);
      chk("t2_lat", wait_cnt, 0);

      // Bubbles, held result, start poked while done.
      for (int i = 0; i < 4; i++) begin
         op_a[i] = 8'(i + 1);
         op_b[i] = 8'(i + 1);
      end
      run_job(4, 1, 5, 1'b1);
      chk("t3_acc",   res24, 30);
      chk("t3_model", m_sum, 30);
      repeat (2) @(negedge clk);
      chk("t3_idle", busy24, 0);

      // Overflow in the 16-bit lane, then cleared by the next job.
      op_a[0] = 8'd255; op_b[0] = 8'd255;
      op_a[1] = 8'd255; op_b[1] = 8'd255;
      run_job(2, 0, 0, 1'b0);
      chk("t4_acc16", res16,  64514);
      chk("t4_ovf16", rovf16, 1);
      chk("t4_acc24", res24,  130050);
      chk("t4_ovf24", rovf24, 0);
      op_a[0] = 8'd1; op_b[0] = 8'd1;
      run_job(1, 0, 0, 1'b0);
      chk("t4b_acc16", res16,  1);
      chk("t4b_ovf16", rovf16, 0);

      // Reset in the middle of a job.
      start = 1'b1;
      len   = 8'd4;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      a_in     = 8'd5;
      b_in     = 8'd6;
      @(negedge clk);
      a_in = 8'd7;
      b_in = 8'd8;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy",      busy24,      0);
      chk("t5_in_ready",  in_ready24,  0);
      chk("t5_out_valid", out_valid24, 0);
      chk("t5_acc",       acc24,       0);
      chk("t5_ovf",       ovf24,       0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op_a[0] = 8'd7; op_b[0] = 8'd9;
      run_job(1, 0, 0, 1'b0);
      chk("t5_acc_after", res24,  63);
      chk("t5_ovf_after", rovf24, 0);

      // Operands offered while idle are ignored.
      in_valid = 1'b1;
      a_in     = 8'd9;
      b_in     = 8'd9;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      op_a[0] = 8'd3; op_b[0] = 8'd3;
      run_job(1, 0, 0, 1'b0);
      chk("t6_acc", res24, 9);

      // Randomized jobs with random gaps, holds and stray starts.
      for (int j = 0; j < 40; j++) begin
         n = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 255) : $urandom_range(0, 12);
         for (int i = 0; i < 256; i++) begin
            op_a[i] = 8'($urandom);
            op_b[i] = 8'($urandom);
         end
         run_job(n, $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 1) != 0);
         repeat ($urandom_range(0, 3)) begin
            in_valid = $urandom_range(0, 1) != 0;
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b0;
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_vedic_mac_ctrl

// File: doc/vedic_mac_ctrl.md
Name: vedic_mac_ctrl

Overview:
Sequencer for one MAC lane built around the team's existing combinational Vedic_8x8_Multiplier. It accepts a start command with a vector length, then streams unsigned 8-bit operand pairs over a valid/ready handshake. Each pair goes through a registered multiply pipeline into an accumulator. The block presents the dot product over an output valid/ready handshake. It sits between the neural-network operand fetch logic and the result writeback.

Parameters:
ACC_W, 24, accumulator/result width in bits; must be at least 16.
CNT_W, 8, width of the length field; the maximum vector length is 2^CNT_W-1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  command pulse; sampled only in IDLE.
len  in  CNT_W  number of operand pairs; sampled with start.
in_valid  in  1  operand pair valid.
in_ready  out  1  block accepts an operand pair this cycle.
a_in  in  8  unsigned operand A.
b_in  in  8  unsigned operand B.
busy  out  1  state is not IDLE.
out_valid  out  1  acc_out holds the final result.
out_ready  in  1  consumer accepts the result.
acc_out  out  ACC_W  accumulator value.
overflow  out  1  sticky flag: the accumulation carried out of ACC_W during the current job.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - The remaining-beats counter, operand registers, product register, both pipeline valid bits, acc_out and overflow all clear to 0.
  - in_ready, busy and out_valid are 0.
  - Asserting reset mid-job aborts the job. No partial result is ever flagged valid.
- State machine states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0. in_valid is ignored.
  - When start=1: clear acc_out and overflow, and load the counter with len.
  - If len=0, go to DONE. out_valid is then high in the cycle after start, with acc_out=0.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid and in_ready are both 1 at a clock edge. On acceptance: a_in/b_in latch into the operand registers, the stage-1 valid bit sets, and the counter decrements.
  - Gaps in in_valid are allowed and stall nothing.
  - When the final beat is accepted (counter was 1), go to DRAIN. in_ready drops in the following cycle.
- Pipeline (runs in every state):
  - Stage 1: operand registers feed Vedic_8x8_Multiplier.
  - Stage 2: the 16-bit product registers, with the stage-2 valid bit copied from stage 1.
  - Accumulate: when stage-2 valid is set, acc_out <= acc_out + zero-extended product, truncated to ACC_W. Any carry out of ACC_W sets overflow, which stays set until the next start. acc_out wraps on overflow.
  - Latency: if the last handshake occurs in cycle 0, out_valid=1 in cycle 3 with the final sum.
- DRAIN:
  - in_ready=0.
  - Go to DONE on the edge where the final product is accumulated, i.e. when stage-2 valid is set and stage-1 valid is clear.
- DONE:
  - out_valid=1. acc_out and overflow are held stable.
  - On the edge where out_ready=1, go to IDLE. out_valid drops in the next cycle.
  - start is ignored in DONE, including in the handshake cycle.
- start while busy is ignored. len is only sampled in IDLE.
- busy=1 in LOAD, DRAIN and DONE.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, LOAD, DRAIN, DONE, 2-bit encoding);
  - the operand width constant (8);
  - the product width constant (16);
  - the default ACC_W.
- The only sub-module is the existing Vedic_8x8_Multiplier, instantiated unchanged. The FSM, counter, pipeline registers and accumulator stay in vedic_mac_ctrl.

Test Plan:
1. Back-to-back run: start, len=3, pairs (2,3), (4,5), (255,255) on consecutive cycles -> out_valid 3 cycles after the last handshake, acc_out=65051, overflow=0.
2. Zero length: start, len=0 -> out_valid=1 in the next cycle, acc_out=0, in_ready never asserted.
3. Bubbles and backpressure: len=4, pairs (i+1,i+1) for i=0..3 with in_valid high every other cycle; hold out_ready=0 for 5 cycles and pulse start during DONE -> acc_out=30 held, out_valid held, start ignored, busy=1 until the handshake.
4. Overflow: ACC_W=16, len=2, (255,255) twice -> acc_out=64514, overflow=1. A following start with len=1 and pair (1,1) -> acc_out=1, overflow=0.
5. Reset mid-job: len=4, deassert rst_n after 2 beats -> all outputs 0 immediately. Then start with len=1 and pair (7,9) -> acc_out=63, overflow=0.
6. Ignored input: in_valid=1 with (9,9) while in IDLE -> no accumulation. A subsequent job with len=1 and pair (3,3) -> acc_out=9.
